// File: rtl/present80_nibble_engine.sv
// rtl/present80_nibble_engine.sv - nibble-serial PRESENT-80 encryption engine
// One state S-box shared across 16 SUB cycles per round, then a single PERM cycle with the key update.
module present80_nibble_engine #(
    parameter int ROUNDS = 31
) (
    input  logic        Clk_ik,
    input  logic        Reset_ir,
    input  logic [63:0] PlainText_ib,
    input  logic [79:0] Key_ib,
    input  logic        Start_i,
    output logic [63:0] CipherText_ob,
    output logic        Ready_o
);

    typedef enum logic [1:0] {IDLE, SUB, PERM} fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [63:0] state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [4:0]  rc_q, rc_d;
    logic [3:0]  nc_q, nc_d;
    logic [63:0] ct_q, ct_d;
    logic        ready_q, ready_d;

    logic [79:0] key_rot;
    logic [79:0] key_next;
    logic [63:0] perm_out;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Bit i lands at 16*i mod 63; bit 63 is a fixed point of the permutation.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[6'((16 * i) % 63)] = x[6'(i)];
        end
        y[63] = x[63];
        return y;
    endfunction

    always_comb begin
        key_rot            = {key_q[18:0], key_q[79:19]};
        key_next           = key_rot;
        key_next[79:76]    = sbox(key_rot[79:76]);
        key_next[19:15]    = key_rot[19:15] ^ rc_q;
        perm_out           = p_layer(state_q) ^ key_next[79:16];
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        nc_d    = nc_q;
        ct_d    = ct_q;
        ready_d = ready_q;
        case (fsm_q)
            IDLE: begin
                if (Start_i) begin
                    state_d = PlainText_ib ^ Key_ib[79:16];
                    key_d   = Key_ib;
                    rc_d    = 5'd1;
                    nc_d    = 4'd0;
                    ready_d = 1'b0;
                    fsm_d   = SUB;
                end
            end
            SUB: begin
                state_d = {sbox(state_q[3:0]), state_q[63:4]};
                nc_d    = nc_q + 4'd1;
                if (nc_q == 4'd15) begin
                    fsm_d = PERM;
                end
            end
            PERM: begin
                state_d = perm_out;
                key_d   = key_next;
                if (rc_q == 5'(ROUNDS)) begin
                    // Final round key doubles as post-whitening, so the result is ready on this edge.
                    ct_d    = perm_out;
                    ready_d = 1'b1;
                    fsm_d   = IDLE;
                end else begin
                    rc_d  = rc_q + 5'd1;
                    nc_d  = 4'd0;
                    fsm_d = SUB;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_ik) begin
        if (Reset_ir) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rc_q    <= '0;
            nc_q    <= '0;
            ct_q    <= '0;
            ready_q <= 1'b1;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            nc_q    <= nc_d;
            ct_q    <= ct_d;
            ready_q <= ready_d;
        end
    end

    assign CipherText_ob = ct_q;
    assign Ready_o       = ready_q;

endmodule

// File: tb/tb_present80_nibble_engine.sv
// tb/tb_present80_nibble_engine.sv - self-checking bench for present80_nibble_engine
// Cycle-level reference: full-width PRESENT-80 computed at load, released LAT edges later.
module tb_present80_nibble_engine;

    localparam int ROUNDS = 31;
    localparam int LAT    = 17 * ROUNDS;
    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] ONES80 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [63:0] pt    = '0;
    logic [79:0] key   = '0;
    logic [63:0] ct;
    logic        ready;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    logic        m_ready = 1'b1;
    logic [63:0] m_ct    = '0;
    logic [63:0] m_pend  = '0;
    int          m_cnt   = 0;

    present80_nibble_engine #(.ROUNDS(ROUNDS)) dut (
        .Clk_ik       (clk),
        .Reset_ir     (rst),
        .PlainText_ib (pt),
        .Key_ib       (key),
        .Start_i      (start),
        .CipherText_ob(ct),
        .Ready_o      (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] present80_ref(input logic [63:0] p, input logic [79:0] k0,
                                                  input int rounds);
        logic [63:0] s;
        logic [63:0] t;
        logic [79:0] k;
        s = p;
        k = k0;
        for (int r = 1; r <= rounds; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) begin
                s[6'(4 * n) +: 4] = SBOX[s[6'(4 * n) +: 4]];
            end
            t = '0;
            for (int b = 0; b < 64; b++) begin
                t[6'(16 * (b % 4) + b / 4)] = s[6'(b)];
            end
            s = t;
            k = (k << 61) | (k >> 19);
            k[79:76] = SBOX[k[79:76]];
            k = k ^ (80'(r) << 15);
        end
        return s ^ k[79:16];
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1'b1;
            m_ct    = '0;
            m_cnt   = 0;
        end else if (m_ready) begin
            if (start) begin
                m_ready = 1'b0;
                m_pend  = present80_ref(pt, key, ROUNDS);
                m_cnt   = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt == LAT) begin
                m_ready = 1'b1;
                m_ct    = m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ready", 80'(ready), 80'(m_ready));
            check("cyc_ct", 80'(ct), 80'(m_ct));
        end
    end

    task automatic wait_ready(input string nm);
        int w;
        w = 0;
        while (!ready && w < 2000) begin
            @(posedge clk);
            #2;
            w++;
        end
        check({nm, "_idle"}, 80'(ready), 80'(1));
    endtask

    task automatic run_vec(input logic [63:0] p, input logic [79:0] k, input logic [63:0] exp,
                           input string nm, input bit disturb);
        int          n;
        int          lat;
        int          rises;
        bit          hold_bad;
        logic        prev_rdy;
        logic [63:0] prev_ct;
        wait_ready(nm);
        pt    = p;
        key   = k;
        start = 1'b1;
        @(posedge clk);
        #2;
        start    = 1'b0;
        prev_ct  = ct;
        prev_rdy = ready;
        check({nm, "_busy"}, 80'(ready), 80'(0));
        n        = 0;
        lat      = -1;
        rises    = 0;
        hold_bad = 1'b0;
        while (n < LAT + 20) begin
            if (disturb && n < LAT - 30) begin
                start = 1'($urandom_range(0, 1));
                pt    = {$urandom, $urandom};
                key   = {$urandom, $urandom, 16'($urandom)};
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #2;
            n++;
            if (ready && !prev_rdy) begin
                rises++;
                if (rises == 1) lat = n;
            end
            if (!ready && ct !== prev_ct) hold_bad = 1'b1;
            prev_rdy = ready;
        end
        check({nm, "_latency"}, 80'(lat), 80'(LAT));
        check({nm, "_rises"}, 80'(rises), 80'(1));
        check({nm, "_hold"}, 80'(hold_bad), 80'(0));
        check({nm, "_ct"}, 80'(ct), 80'(exp));
    endtask

    initial begin
        check("model_pin_zero", 80'(present80_ref('0, '0, ROUNDS)), 80'(64'h5579C1387B228445));
        check("model_pin_ones", 80'(present80_ref(ONES64, ONES80, ROUNDS)),
              80'(64'h3333DCD3213210D2));

        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset_ready", 80'(ready), 80'(1));
        check("reset_ct", 80'(ct), 80'(0));

        run_vec('0, '0, 64'h5579C1387B228445, "v_zero", 1'b0);
        run_vec('0, ONES80, 64'hE72C46C0F5945049, "v_keyff", 1'b0);
        run_vec(ONES64, '0, 64'hA112FFC72F68417B, "v_ptff", 1'b0);
        run_vec(ONES64, ONES80, 64'h3333DCD3213210D2, "v_allff", 1'b0);
        run_vec('0, ONES80, 64'hE72C46C0F5945049, "v_disturb", 1'b1);

        // Abort a run mid-flight; nothing from it may reach the output.
        wait_ready("rst_run");
        pt    = 64'h0123_4567_89AB_CDEF;
        key   = 80'h1357_9BDF_2468_ACE0_1122;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (199) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("midrun_reset_ready", 80'(ready), 80'(1));
        check("midrun_reset_ct", 80'(ct), 80'(0));
        run_vec('0, '0, 64'h5579C1387B228445, "v_after_rst", 1'b0);

        // Start held high across two runs; second key switched after the first load edge.
        begin
            int n;
            wait_ready("b2b");
            pt    = '0;
            key   = '0;
            start = 1'b1;
            @(posedge clk);
            #2;
            key = ONES80;
            n   = 0;
            while (!ready && n < LAT + 20) begin
                @(posedge clk);
                #2;
                n++;
            end
            check("b2b_lat1", 80'(n), 80'(LAT));
            check("b2b_ct1", 80'(ct), 80'(64'h5579C1387B228445));
            @(posedge clk);
            #2;
            check("b2b_accept", 80'(ready), 80'(0));
            n = 0;
            while (!ready && n < LAT + 20) begin
                @(posedge clk);
                #2;
                n++;
            end
            start = 1'b0;
            check("b2b_lat2", 80'(n), 80'(LAT));
            check("b2b_ct2", 80'(ct), 80'(64'hE72C46C0F5945049));
            repeat (3) @(posedge clk);
            #2;
            check("b2b_stop", 80'(ready), 80'(1));
        end

        @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/present80_nibble_engine.md
# present80_nibble_engine

Nibble-serial PRESENT-80 block-cipher encryption engine, the cryptographic datapath driven by the 8-bit register front-end. It accepts a 64-bit plaintext and an 80-bit key on a start pulse and runs 31 rounds through a single shared state S-box. It returns the 64-bit ciphertext in a stable output register with a ready flag. It is sized for a tiny-tile ASIC slot, trading latency for area.

## Interface
- ROUNDS, default 31, number of cipher rounds; only 31 yields standard PRESENT-80, other values are for debug only.
- Clk_ik  input  1  single clock, all state updates on rising edge.
- Reset_ir  input  1  synchronous, active-high reset.
- PlainText_ib  input  64  plaintext, bit 63 = MSB; sampled only on the accepting edge.
- Key_ib  input  80  key, bit 79 = MSB; sampled only on the accepting edge.
- Start_i  input  1  start request; level-sampled, acted on only while idle.
- CipherText_ob  output  64  result register; holds the last completed ciphertext.
- Ready_o  output  1  1 = idle and able to accept Start_i; 0 = busy.

## Operation
- Registers:
  - State[63:0], KeyReg[79:0].
  - Round counter Rc[4:0], 1..ROUNDS.
  - Nibble counter Nc[3:0].
  - FSM: IDLE, SUB, PERM.
- S-box S, input 0..F maps to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2. There are two instances: one on the state, one on the key.
- Round key is KeyReg[79:16].
- IDLE with Start_i=1 (load edge):
  - State <= PlainText_ib ^ Key_ib[79:16]; KeyReg <= Key_ib.
  - Rc <= 1; Nc <= 0; Ready_o <= 0; go to SUB.
- SUB, 16 cycles, one per edge:
  - State <= {S(State[3:0]), State[63:4]}, i.e. rotate right one nibble with the low nibble substituted.
  - After 16 edges every nibble is substituted and back in place.
  - Nc increments; on Nc=15 go to PERM.
- PERM, 1 cycle. Let Kn be the key update of KeyReg with Rc:
  - Rotate left by 61: t = {KeyReg[18:0], KeyReg[79:19]}.
  - t[79:76] = S(t[79:76]).
  - t[19:15] ^= Rc.
- On the PERM edge:
  - State <= P(State) ^ Kn[79:16], where P moves bit i to bit (16*i mod 63) for i<63 and bit 63 stays at 63.
  - KeyReg <= Kn.
- PERM when Rc < ROUNDS: Rc <= Rc+1; Nc <= 0; go to SUB.
- PERM when Rc = ROUNDS:
  - On this same edge CipherText_ob <= P(State) ^ Kn[79:16] and Ready_o <= 1; go to IDLE.
  - This final XOR is the post-whitening with K32.
- CipherText_ob changes only on a completion edge and on reset. It is never partially updated and stays readable while busy.
- Start_i while busy is ignored, with no queuing. Input changes after the load edge have no effect.

## Timing
- Reset (synchronous, overrides everything, including mid-encryption):
  - FSM=IDLE, Ready_o=1, CipherText_ob=0.
  - State, KeyReg, Rc and Nc are cleared to 0.
  - Any running operation is discarded with no partial result.
- Start_i=1 sampled on edge E0 (FSM in IDLE) makes Ready_o=0 after E0.
- Per-round cost is 17 cycles (16 SUB + 1 PERM).
- Round r's PERM is at edge E0+17r. For ROUNDS=31, CipherText_ob is valid and Ready_o=1 after edge E0+527.
- Back-to-back operation: Start_i held high is accepted on the first edge after Ready_o rises. The new run starts at E0+528, and that result lands at E0+1055.
- Reset asserted on the same edge as the completion or load edge: reset wins.

## Test plan
- PT=0000000000000000, K=00000000000000000000 -> CipherText_ob=5579C1387B228445; Ready_o low for exactly 527 cycles after the start edge.
- PT=0000000000000000, K=FFFFFFFFFFFFFFFFFFFF -> E72C46C0F5945049.
- PT=FFFFFFFFFFFFFFFF, K=00000000000000000000 -> A112FFC72F68417B. Then PT=all ones, K=all ones -> 3333DCD3213210D2; the first result must stay on CipherText_ob until the second completes.
- Start_i re-pulsed and PlainText_ib/Key_ib changed randomly mid-run -> result identical to the undisturbed vector; Ready_o rises exactly once.
- Reset asserted at cycle 200 of a run -> next edge Ready_o=1, CipherText_ob=0. A fresh start with PT=0, K=0 then yields 5579C1387B228445 at +527.
- Start_i held high continuously for two runs -> both results correct; second run's start edge is exactly 1 cycle after the first Ready_o rise.
